// File: rtl/div_bcd_formatter_pkg.sv
// Shared constants and state encoding for the divider BCD formatter.
// Optional leading-zero blanking: define DIV_BCD_BLANK_EN.
package div_disp_pkg;

  localparam int W_DEF      = 16;
  localparam int DIGITS_DEF = 5;
  localparam int CNT_W      = $clog2(W_DEF);

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/div_bcd_formatter_if.sv
// Capture request and BCD result bundle between divider,
// formatter and seven-segment driver.
interface div_bcd_formatter_if
  import div_disp_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic                  start;
  logic [W-1:0]          quotient;
  logic [W-1:0]          remainder;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;

  modport master (
    output start,
    output quotient,
    output remainder,
    input  busy,
    input  done,
    input  q_bcd,
    input  r_bcd
  );

  modport slave (
    input  start,
    input  quotient,
    input  remainder,
    output busy,
    output done,
    output q_bcd,
    output r_bcd
  );

endinterface

// File: rtl/div_bcd_formatter_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] y
);

  assign y = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/div_bcd_formatter.sv
// Sequential double-dabble of divider quotient and remainder.
// Build with DIV_BCD_BLANK_EN to blank leading zero digits as 4'hF.
module div_bcd_formatter
  import div_disp_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  div_bcd_formatter_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   q_sr;
  logic [SW-1:0]   r_sr;
  logic [SW-1:0]   q_fix;
  logic [SW-1:0]   r_fix;
  logic [SW-1:0]   q_nxt;
  logic [SW-1:0]   r_nxt;
  logic [BW-1:0]   q_load;
  logic [BW-1:0]   r_load;
  logic            busy_r;
  logic            done_r;
  logic [BW-1:0]   q_out;
  logic [BW-1:0]   r_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_add3 u_q (
      .d (q_sr[W+4*g +: 4]),
      .y (q_fix[W+4*g +: 4])
    );
    bcd_add3 u_r (
      .d (r_sr[W+4*g +: 4]),
      .y (r_fix[W+4*g +: 4])
    );
  end

  assign q_fix[W-1:0] = q_sr[W-1:0];
  assign r_fix[W-1:0] = r_sr[W-1:0];

  assign q_nxt = {q_fix[SW-2:0], 1'b0};
  assign r_nxt = {r_fix[SW-2:0], 1'b0};

`ifdef DIV_BCD_BLANK_EN
  // Leading zeros blank from the top down; digit 0 always shows.
  always_comb begin
    logic q_lz;
    logic r_lz;
    q_load = q_nxt[SW-1:W];
    r_load = r_nxt[SW-1:W];
    q_lz   = 1'b1;
    r_lz   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      q_lz = q_lz & (q_nxt[W+4*i +: 4] == 4'd0);
      r_lz = r_lz & (r_nxt[W+4*i +: 4] == 4'd0);
      if (q_lz) q_load[4*i +: 4] = BLANK_NIBBLE;
      if (r_lz) r_load[4*i +: 4] = BLANK_NIBBLE;
    end
  end
`else
  assign q_load = q_nxt[SW-1:W];
  assign r_load = r_nxt[SW-1:W];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      q_sr   <= '0;
      r_sr   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_out  <= '0;
      r_out  <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            q_sr   <= {{BW{1'b0}}, bus.quotient};
            r_sr   <= {{BW{1'b0}}, bus.remainder};
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          q_sr <= q_nxt;
          r_sr <= r_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            q_out  <= q_load;
            r_out  <= r_load;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.q_bcd = q_out;
  assign bus.r_bcd = r_out;

endmodule
